// File: rtl/bus_target_responder.sv
// Strobed-bus memory target: decodes AS/DS/RW accesses into a word-addressed
// register file and completes them with DSACK, or BERR when misaligned.
module bus_target_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h00F0_0000,
    parameter int          MEM_ADDR_BITS  = 8,
    parameter int          WAIT_STATES    = 2,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        comm_clock,
    input  logic        reset_n,
    input  logic        as_n,
    input  logic        ds_n,
    input  logic        rw,
    input  logic [31:0] ad_in,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        data_dir,
    output logic [1:0]  dsack_n,
    output logic        berr_n,
    output logic        busy
);

    localparam int TAG_LSB = MEM_ADDR_BITS + 2;
    localparam int DEPTH   = 1 << MEM_ADDR_BITS;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > WAIT_STATES + 1) ? TIMEOUT_CYCLES : WAIT_STATES + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(WAIT_STATES);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT_DS,
        ACCESS,
        ACK,
        ERR,
        IDLE_WAIT
    } state_t;

    state_t state_q, state_d;

    logic as_meta_q, as_s_q;
    logic ds_meta_q, ds_s_q;
    logic rw_meta_q, rw_s_q;

    logic [31:0]      addr_q, addr_d;
    logic             rw_l_q, rw_l_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ad_out_q, ad_out_d;
    logic             ad_oe_q, ad_oe_d;
    logic             data_dir_q, data_dir_d;
    logic [1:0]       dsack_n_q, dsack_n_d;
    logic             berr_n_q, berr_n_d;
    logic             busy_q, busy_d;

    logic [31:0]              mem_q [DEPTH];
    logic                     mem_we;
    logic [MEM_ADDR_BITS-1:0] mem_idx;
    logic                     hit;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rw_l_d     = rw_l_q;
        cnt_d      = cnt_q;
        ad_out_d   = ad_out_q;
        ad_oe_d    = ad_oe_q;
        data_dir_d = data_dir_q;
        dsack_n_d  = dsack_n_q;
        berr_n_d   = berr_n_q;
        mem_we     = 1'b0;
        mem_idx    = addr_q[TAG_LSB-1:2];
        hit        = (addr_q[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

        case (state_q)
            IDLE: begin
                if (!as_s_q) begin
                    addr_d  = ad_in;
                    rw_l_d  = rw_s_q;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                cnt_d = '0;
                if (!hit) begin
                    state_d = IDLE_WAIT;
                end else if (addr_q[1:0] != 2'b00) begin
                    state_d = ERR;
                end else begin
                    state_d = WAIT_DS;
                end
            end
            WAIT_DS: begin
                if (!ds_s_q) begin
                    if (rw_l_q) begin
                        ad_out_d   = mem_q[mem_idx];
                        ad_oe_d    = 1'b1;
                        data_dir_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = ACCESS;
                end else if (as_s_q) begin
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = IDLE_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // One pass-through cycle plus WAIT_STATES extra before acknowledging.
            ACCESS: begin
                if (cnt_q == WAIT_LAST) begin
                    dsack_n_d = 2'b00;
                    state_d   = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                if (as_s_q) begin
                    dsack_n_d  = 2'b11;
                    ad_oe_d    = 1'b0;
                    data_dir_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            ERR: begin
                if (!berr_n_q) begin
                    if (as_s_q) begin
                        berr_n_d = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    berr_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_WAIT: begin
                if (as_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            as_meta_q  <= 1'b1;
            as_s_q     <= 1'b1;
            ds_meta_q  <= 1'b1;
            ds_s_q     <= 1'b1;
            rw_meta_q  <= 1'b0;
            rw_s_q     <= 1'b0;
            state_q    <= IDLE;
            addr_q     <= '0;
            rw_l_q     <= 1'b0;
            cnt_q      <= '0;
            ad_out_q   <= '0;
            ad_oe_q    <= 1'b0;
            data_dir_q <= 1'b0;
            dsack_n_q  <= 2'b11;
            berr_n_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            as_meta_q  <= as_n;
            as_s_q     <= as_meta_q;
            ds_meta_q  <= ds_n;
            ds_s_q     <= ds_meta_q;
            rw_meta_q  <= rw;
            rw_s_q     <= rw_meta_q;
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_l_q     <= rw_l_d;
            cnt_q      <= cnt_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            data_dir_q <= data_dir_d;
            dsack_n_q  <= dsack_n_d;
            berr_n_q   <= berr_n_d;
            busy_q     <= busy_d;
        end
    end

    // Register file contents deliberately survive reset.
    always_ff @(posedge comm_clock) begin
        if (mem_we) begin
            mem_q[mem_idx] <= ad_in;
        end
    end

    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign data_dir = data_dir_q;
    assign dsack_n  = dsack_n_q;
    assign berr_n   = berr_n_q;
    assign busy     = busy_q;

endmodule
